// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM signal bundle shared by the requester ports and the memory port.
// The master modport drives commands; the slave modport accepts them and answers.
interface avalon_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_BYTES = 2
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_BYTES-1:0]   byteenable;
    logic                    read;
    logic                    write;
    logic [8*DATA_BYTES-1:0] writedata;
    logic [8*DATA_BYTES-1:0] readdata;
    logic                    waitrequest;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-requester Avalon-MM arbiter: zero-latency forwarding, round-robin on ties,
// grant held across waitrequest, read responses routed back via an in-order ID FIFO.
module avalon_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_BYTES  = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    avalon_mem_arbiter_if.slave  avs_a,
    avalon_mem_arbiter_if.slave  avs_b,
    avalon_mem_arbiter_if.master avm,
    output logic                 error
);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD_A, ST_HOLD_B} state_e;

    state_e                     state_q, state_d;
    req_id_e                    last_q, last_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       error_q, error_d;
    req_id_e                    fifo_q [MAX_PENDING];

    logic                       fifo_full, fifo_empty;
    logic                       req_a, req_b, elig_a, elig_b;
    logic                       grant_valid;
    req_id_e                    grant_id;
    logic                       sel_read, sel_write;
    logic                       accept, push, pop;
    req_id_e                    head;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        fifo_full   = (count_q == CNT_W'(MAX_PENDING));
        fifo_empty  = (count_q == '0);
        req_a       = avs_a.read | avs_a.write;
        req_b       = avs_b.read | avs_b.write;
        elig_a      = req_a & (~avs_a.read | ~fifo_full);
        elig_b      = req_b & (~avs_b.read | ~fifo_full);
        grant_valid = 1'b0;
        grant_id    = REQ_A;

        if (!reset) begin
            case (state_q)
                ST_HOLD_A: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_A;
                end
                ST_HOLD_B: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_B;
                end
                default: begin
                    if (elig_a && elig_b) begin
                        grant_valid = 1'b1;
                        grant_id    = (last_q == REQ_A) ? REQ_B : REQ_A;
                    end else if (elig_a) begin
                        grant_valid = 1'b1;
                        grant_id    = REQ_A;
                    end else if (elig_b) begin
                        grant_valid = 1'b1;
                        grant_id    = REQ_B;
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_read           = (grant_id == REQ_B) ? avs_b.read : avs_a.read;
        sel_write          = (grant_id == REQ_B) ? avs_b.write : avs_a.write;
        avm.address        = (grant_id == REQ_B) ? avs_b.address : avs_a.address;
        avm.byteenable     = (grant_id == REQ_B) ? avs_b.byteenable : avs_a.byteenable;
        avm.writedata      = (grant_id == REQ_B) ? avs_b.writedata : avs_a.writedata;
        // A read+write collision forwards only the read.
        avm.read           = grant_valid & sel_read;
        avm.write          = grant_valid & sel_write & ~sel_read;

        avs_a.waitrequest  = ~(grant_valid & (grant_id == REQ_A)) | avm.waitrequest;
        avs_b.waitrequest  = ~(grant_valid & (grant_id == REQ_B)) | avm.waitrequest;

        accept             = grant_valid & ~avm.waitrequest;
        push               = accept & sel_read;
        pop                = avm.readdatavalid & ~fifo_empty;
        head               = fifo_q[rd_ptr_q];

        avs_a.readdata      = avm.readdata;
        avs_b.readdata      = avm.readdata;
        avs_a.readdatavalid = ~reset & pop & (head == REQ_A);
        avs_b.readdatavalid = ~reset & pop & (head == REQ_B);
        error               = error_q;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (grant_valid) begin
            if (avm.waitrequest) begin
                state_d = (grant_id == REQ_A) ? ST_HOLD_A : ST_HOLD_B;
            end else begin
                state_d = ST_IDLE;
                last_d  = grant_id;
            end
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        error_d  = error_q
                 | (avs_a.read & avs_a.write)
                 | (avs_b.read & avs_b.write)
                 | (avm.readdatavalid & fifo_empty);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= REQ_B;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // NOTE: ID storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant_id;
        end
    end
endmodule
